// File: rtl/add_seq.sv
// Nibble-serial adder: one shared 4-bit ripple slice plus a carry register, NIB = WIDTH/4 cycles per result.
// Define ADD_SEQ_SUB_EN to add the sub input (a - b via inverted b and carry-in forced to 1).
module add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_init;
  logic [3:0]       na;
  logic [3:0]       nb;
  logic [3:0]       ns;
  logic [4:0]       c;
  logic [WIDTH-1:0] sum_next;

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
`ifdef ADD_SEQ_SUB_EN
    b_eff  = sub ? ~b : b;
    c_init = sub ? 1'b1 : cin;
`else
    b_eff  = b;
    c_init = cin;
`endif
  end

  // Bit 0 is a half adder on the operands with the carry register folded in.
  always_comb begin
    na    = a_r[{cnt, 2'b00} +: 4];
    nb    = b_r[{cnt, 2'b00} +: 4];
    ns    = '0;
    c     = '0;
    ns[0] = (na[0] ^ nb[0]) ^ carry;
    c[1]  = (na[0] & nb[0]) | ((na[0] ^ nb[0]) & carry);
    for (int unsigned i = 1; i < 4; i++) begin
      ns[i]  = na[i] ^ nb[i] ^ c[i];
      c[i+1] = (na[i] & nb[i]) | (na[i] & c[i]) | (nb[i] & c[i]);
    end
    sum_next = sum >> 4;
    sum_next[WIDTH-1 -: 4] = ns;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN:     state_next = (cnt == LAST) ? DONE : RUN;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b_eff;
      carry <= c_init;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      sum   <= sum_next;
      carry <= c[4];
      cnt   <= cnt + 1'b1;
      if (cnt == LAST)
        ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (ns[3] != a_r[WIDTH-1]);
    end
  end

  assign cout = carry;

endmodule

// File: tb/tb_add_seq.sv
// Randomized bench for add_seq (WIDTH=16) against an arithmetic reference model.
module tb_add_seq;
  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] be;
    logic [16:0] full;
    logic        v;
    be   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {16'd0, (ms ? 1'b1 : mc)};
    v    = (ma[15] == be[15]) && (full[15] != ma[15]);
    return {v, full[16], full[15:0]};
  endfunction

  // Drives one operation from posedge+1 and waits (bounded) for done.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic ts, output logic [15:0] s, output logic co,
                       output logic ov, output int lat, output logic busy_ok);
    a = ta; b = tb; cin = tc;
`ifdef ADD_SEQ_SUB_EN
    sub = ts;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    s = sum; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (sum !== 16'h0) begin fails++; $display("FAIL reset_sum got %h want 0000", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b want 0", cout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF};
    logic [15:0] vb [4] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0001};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [4] = '{16'h2233, 16'h0000, 16'h0001, 16'h8000};
    logic        eco [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        eov [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] s;
    logic        co, ov, bok;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], 1'b0, s, co, ov, lat, bok);
      tests++; if (lat !== NIB) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NIB); end
      tests++; if (bok !== 1'b1) begin fails++; $display("FAIL dir%0d_busy got %b want 1", i, bok); end
      tests++; if (s !== es[i]) begin fails++; $display("FAIL dir%0d_sum got %h want %h", i, s, es[i]); end
      tests++; if (co !== eco[i]) begin fails++; $display("FAIL dir%0d_cout got %b want %b", i, co, eco[i]); end
      tests++; if (ov !== eov[i]) begin fails++; $display("FAIL dir%0d_ovf got %b want %b", i, ov, eov[i]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] s;
    logic        co, ov, bok;
    int          lat;
    do_op(16'hA5A5, 16'h1357, 1'b1, 1'b0, s, co, ov, lat, bok);
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      tests++; if (sum !== 16'hB8FD) begin fails++; $display("FAIL hold%0d_sum got %h want b8fd", k, sum); end
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL hold%0d_ctrl got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, s;
    logic        rc, rs, co, ov, bok;
    logic [17:0] exp;
    int          lat;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp = model(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, s, co, ov, lat, bok);
      tests++;
      if (lat !== NIB || s !== exp[15:0] || co !== exp[16] || ov !== exp[17]) begin
        fails++;
        $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
                 i, ra, rb, rc, rs, lat, s, co, ov, NIB, exp[15:0], exp[16], exp[17]);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] q[$];
    logic [17:0] exp;
    logic        accept_next;
    int          since, results;
    repeat (2) @(posedge clk);
    #1;
    accept_next = 1'b1;
    since = 0;
    results = 0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    start = 1'b1;
    for (int cyc = 0; cyc < 42; cyc++) begin
      @(posedge clk);
      if (accept_next) begin
        q.push_back(model(a, b, cin, 1'b0));
        since = 0;
        accept_next = 1'b0;
      end else begin
        since++;
      end
      #1;
      tests++; if (done !== (since == NIB)) begin
        fails++; $display("FAIL b2b_done cyc=%0d got %b want %b", cyc, done, (since == NIB));
      end
      tests++; if (busy !== (since < NIB)) begin
        fails++; $display("FAIL b2b_busy cyc=%0d got %b want %b", cyc, busy, (since < NIB));
      end
      if (since == NIB) begin
        accept_next = 1'b1;
        if (q.size() > 0) begin
          exp = q.pop_front();
          results++;
          tests++; if ({ovf, cout, sum} !== exp) begin
            fails++; $display("FAIL b2b_result cyc=%0d got %h want %h", cyc, {ovf, cout, sum}, exp);
          end
        end
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    tests++; if (results != 8) begin fails++; $display("FAIL b2b_count got %0d want 8", results); end
  endtask

  task automatic test_reset_abort();
    int saw;
    repeat (2) @(posedge clk);
    #1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", done); end
    tests++; if (sum !== 16'h0) begin fails++; $display("FAIL abort_sum got %h want 0000", sum); end
    tests++; if (cout !== 1'b0 || ovf !== 1'b0) begin
      fails++; $display("FAIL abort_flags got cout=%b ovf=%b want 0 0", cout, ovf);
    end
    saw = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw++;
    end
    tests++; if (saw != 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", saw); end
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub();
    logic [15:0] s;
    logic        co, ov, bok;
    int          lat;
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov, lat, bok);
    tests++; if (s !== 16'hFFFE) begin fails++; $display("FAIL sub_sum got %h want fffe", s); end
    tests++; if (co !== 1'b0) begin fails++; $display("FAIL sub_cout got %b want 0", co); end
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL sub_ovf got %b want 0", ov); end
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, s, co, ov, lat, bok);
    tests++; if ({ov, co, s} !== {1'b1, 1'b1, 16'h7FFF}) begin
      fails++; $display("FAIL sub_ovf2 got %h want 37fff", {ov, co, s});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
